// File: rtl/column_arb_pkg.sv
// Shared widths, parameter defaults and FSM state encoding for the column write arbiter.
package column_arb_pkg;
  localparam int N_COLS_DEF  = 64;
  localparam int TIMEOUT_DEF = 255;
  localparam int COL_W       = 6;
  localparam int ROW_W       = 10;
  localparam int COLOR_W     = 8;
  localparam int CNT_W       = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_FLUSH   = 2'd3
  } arb_state_e;
endpackage

// File: rtl/column_write_arbiter_rr_priority2.sv
// Two-way round-robin pick: on contention the requester not granted last wins.
module rr_priority2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  // Grant selection from the current requests and the previous winner.
  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) begin
      gnt_id = ~last;
    end else if (req1) begin
      gnt_id = 1'b1;
    end else begin
      gnt_id = 1'b0;
    end
  end

endmodule

// File: rtl/column_write_arbiter.sv
// Arbitrates two pixel-write requesters onto a bank of column memories, handling the
// strobe/acknowledge handshake with per-phase timeouts.
module column_write_arbiter
  import column_arb_pkg::*;
#(
  parameter int N_COLS  = N_COLS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic [COL_W-1:0]   col0,
  input  logic [COL_W-1:0]   col1,
  input  logic [ROW_W-1:0]   row0,
  input  logic [ROW_W-1:0]   row1,
  input  logic [COLOR_W-1:0] color0,
  input  logic [COLOR_W-1:0] color1,
  output logic               done0,
  output logic               done1,
  output logic               err0,
  output logic               err1,
  output logic [N_COLS-1:0]  col_select,
  output logic [ROW_W-1:0]   row_select,
  output logic [COLOR_W-1:0] pixel_color,
  input  logic [N_COLS-1:0]  return_sig,
  output logic               busy,
  output logic               grant_id
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COLOR_W-1:0]  color_q, color_d;
  logic                gid_q, gid_d;
  logic                last_q, last_d;
  logic [N_COLS-1:0]   col_sel_q, col_sel_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic                busy_q, busy_d;

  logic                gnt_valid_s, gnt_id_s, ack_s;
  logic [COL_W-1:0]    new_col_s;
  logic [N_COLS-1:0]   new_onehot_s, lat_onehot_s;

  rr_priority2 u_rr (
    .req0      (req0),
    .req1      (req1),
    .last      (last_q),
    .gnt_valid (gnt_valid_s),
    .gnt_id    (gnt_id_s)
  );

  assign new_col_s = gnt_id_s ? col1 : col0;

  // Column decode for the incoming grant and for the latched transfer; out-of-range
  // indices decode to no strobe and can never be acknowledged.
  always_comb begin
    new_onehot_s = '0;
    lat_onehot_s = '0;
    for (int i = 0; i < N_COLS; i++) begin
      new_onehot_s[i] = (new_col_s == COL_W'(i));
      lat_onehot_s[i] = (col_q == COL_W'(i));
    end
  end

  assign ack_s = |(return_sig & lat_onehot_s);

  // Next-state and registered-output logic of the transfer FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    color_d   = color_q;
    gid_d     = gid_q;
    last_d    = last_q;
    col_sel_d = '0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          if (gnt_id_s) begin
            row_d   = row1;
            color_d = color1;
          end else begin
            row_d   = row0;
            color_d = color0;
          end
          col_d     = new_col_s;
          gid_d     = gnt_id_s;
          last_d    = gnt_id_s;
          col_sel_d = new_onehot_s;
          cnt_d     = '0;
          state_d   = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Acknowledge wins over a coincident timeout so done/err stay exclusive.
        if (ack_s) begin
          if (gid_q) begin
            done1_d = 1'b1;
          end else begin
            done0_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          if (gid_q) begin
            err1_d = 1'b1;
          end else begin
            err0_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = ST_FLUSH;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          col_sel_d = lat_onehot_s;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_FLUSH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      color_q   <= '0;
      gid_q     <= 1'b0;
      last_q    <= 1'b1;
      col_sel_q <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      color_q   <= color_d;
      gid_q     <= gid_d;
      last_q    <= last_d;
      col_sel_q <= col_sel_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      busy_q    <= busy_d;
    end
  end

  assign col_select  = col_sel_q;
  assign row_select  = row_q;
  assign pixel_color = color_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign err0        = err0_q;
  assign err1        = err1_q;
  assign busy        = busy_q;
  assign grant_id    = gid_q;

endmodule

// File: tb/tb_column_write_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and random traffic
// checked against a transaction-level reference model.
module tb_column_write_arbiter;
  localparam int NC  = 64;
  localparam int TMO = 8;
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_REL = 2, PH_FLUSH = 3;

  logic        clock = 1'b0;
  logic        reset, req0, req1;
  logic [5:0]  col0, col1;
  logic [9:0]  row0, row1;
  logic [7:0]  color0, color1;
  logic [63:0] return_sig;
  logic [63:0] col_select;
  logic [9:0]  row_select;
  logic [7:0]  pixel_color;
  logic        done0, done1, err0, err1, busy, grant_id;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_log[$];

  int m_phase, m_age, m_owner, m_col, m_row, m_color, m_pref;
  bit m_d0, m_d1, m_e0, m_e1;

  always #5 clock = ~clock;

  column_write_arbiter #(.N_COLS(NC), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1),
    .col0(col0), .col1(col1), .row0(row0), .row1(row1),
    .color0(color0), .color1(color1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .col_select(col_select), .row_select(row_select), .pixel_color(pixel_color),
    .return_sig(return_sig), .busy(busy), .grant_id(grant_id)
  );

  typedef struct {
    logic        rst_n, r0, r1;
    logic [5:0]  c0, c1;
    logic [9:0]  w0, w1;
    logic [7:0]  k0, k1;
    logic [63:0] ret;
    int          x_cs;
    logic        x_d0, x_d1, x_e0, x_e1, x_busy, x_gid;
    logic [9:0]  x_row;
    logic [7:0]  x_color;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(logic rst_n, logic r0, logic r1, logic [5:0] c0, logic [5:0] c1,
                              logic [9:0] w0, logic [9:0] w1, logic [7:0] k0, logic [7:0] k1,
                              logic [63:0] ret, int x_cs, logic x_d0, logic x_d1, logic x_busy,
                              logic x_gid, logic [9:0] x_row, logic [7:0] x_color);
    vec_t v;
    v.rst_n = rst_n; v.r0 = r0; v.r1 = r1; v.c0 = c0; v.c1 = c1;
    v.w0 = w0; v.w1 = w1; v.k0 = k0; v.k1 = k1; v.ret = ret;
    v.x_cs = x_cs; v.x_d0 = x_d0; v.x_d1 = x_d1; v.x_e0 = 1'b0; v.x_e1 = 1'b0;
    v.x_busy = x_busy; v.x_gid = x_gid; v.x_row = x_row; v.x_color = x_color;
    return v;
  endfunction

  // Reference model: one transfer at a time, strobe on while waiting for the acknowledge.
  task automatic model_step();
    bit ack;
    int pick;
    m_d0 = 1'b0; m_d1 = 1'b0; m_e0 = 1'b0; m_e1 = 1'b0;
    if (!reset) begin
      m_phase = PH_IDLE; m_age = 0; m_owner = 0; m_col = 0; m_row = 0; m_color = 0; m_pref = 0;
    end else begin
      ack = return_sig[m_col];
      case (m_phase)
        PH_IDLE: begin
          if (req0 || req1) begin
            pick    = (req0 && req1) ? m_pref : (req1 ? 1 : 0);
            m_pref  = 1 - pick;
            m_owner = pick;
            m_col   = pick ? int'(col1) : int'(col0);
            m_row   = pick ? int'(row1) : int'(row0);
            m_color = pick ? int'(color1) : int'(color0);
            m_age   = 0;
            m_phase = PH_WAIT;
          end
        end
        PH_WAIT: begin
          if (ack) begin
            if (m_owner == 1) m_d1 = 1'b1; else m_d0 = 1'b1;
            m_age = 0; m_phase = PH_REL;
          end else if (m_age == TMO - 1) begin
            if (m_owner == 1) m_e1 = 1'b1; else m_e0 = 1'b1;
            m_phase = PH_FLUSH;
          end else begin
            m_age++;
          end
        end
        PH_REL: begin
          if (!ack) m_phase = PH_IDLE;
          else if (m_age == TMO - 1) m_phase = PH_FLUSH;
          else m_age++;
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  endtask

  task automatic check_model();
    logic [63:0] exp_cs;
    exp_cs = (m_phase == PH_WAIT) ? (64'd1 << m_col) : 64'd0;
    n_checks++;
    if (col_select !== exp_cs || row_select !== 10'(m_row) || pixel_color !== 8'(m_color) ||
        done0 !== m_d0 || done1 !== m_d1 || err0 !== m_e0 || err1 !== m_e1 ||
        busy !== (m_phase != PH_IDLE) || grant_id !== 1'(m_owner)) begin
      n_fail++;
      $display("FAIL model t=%0d got cs=%h row=%0d col=%h d=%b%b e=%b%b busy=%b gid=%b exp cs=%h row=%0d col=%h d=%b%b e=%b%b busy=%b gid=%b",
               cyc, col_select, row_select, pixel_color, done0, done1, err0, err1, busy, grant_id,
               exp_cs, m_row, m_color, m_d0, m_d1, m_e0, m_e1, (m_phase != PH_IDLE), m_owner);
    end
    if (done0) done_log.push_back(0);
    if (done1) done_log.push_back(1);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    cyc++;
    check_model();
  endtask

  task automatic check(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; return_sig = '0;
    tick(); tick();
    reset = 1'b1;
    done_log.delete();
  endtask

  initial begin
    int cnt_cs, cnt_e, cnt_d, err_at, busy_after, gid_g;
    int plist[4];
    logic [63:0] r, exp_cs;
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; col0 = '0; col1 = '0; row0 = '0; row1 = '0;
    color0 = '0; color1 = '0; return_sig = '0;

    // Single transfer to column 5 followed by one to column 9.
    tbl[0] = mk(0, 0, 0, 0, 0, 0,  0, 8'h00, 8'h00, 64'd0,       -1, 0, 0, 0, 0, 10'd0,  8'h00);
    tbl[1] = mk(1, 1, 0, 5, 0, 17, 0, 8'hFF, 8'h00, 64'd0,        5, 0, 0, 1, 0, 10'd17, 8'hFF);
    tbl[2] = mk(1, 0, 0, 5, 0, 17, 0, 8'hFF, 8'h00, 64'd0,        5, 0, 0, 1, 0, 10'd17, 8'hFF);
    tbl[3] = mk(1, 0, 0, 5, 0, 17, 0, 8'hFF, 8'h00, 64'd0,        5, 0, 0, 1, 0, 10'd17, 8'hFF);
    tbl[4] = mk(1, 0, 0, 5, 0, 17, 0, 8'hFF, 8'h00, 64'd1 << 5,  -1, 1, 0, 1, 0, 10'd17, 8'hFF);
    tbl[5] = mk(1, 0, 0, 5, 0, 17, 0, 8'hFF, 8'h00, 64'd1 << 5,  -1, 0, 0, 1, 0, 10'd17, 8'hFF);
    tbl[6] = mk(1, 0, 0, 5, 0, 17, 0, 8'hFF, 8'h00, 64'd0,       -1, 0, 0, 0, 0, 10'd17, 8'hFF);
    tbl[7] = mk(1, 0, 1, 0, 9, 0,  3, 8'h00, 8'h0A, 64'd0,        9, 0, 0, 1, 1, 10'd3,  8'h0A);
    tbl[8] = mk(1, 0, 0, 0, 9, 0,  3, 8'h00, 8'h0A, 64'd1 << 9,  -1, 0, 1, 1, 1, 10'd3,  8'h0A);
    tbl[9] = mk(1, 0, 0, 0, 9, 0,  3, 8'h00, 8'h0A, 64'd0,       -1, 0, 0, 0, 1, 10'd3,  8'h0A);

    for (int i = 0; i < 10; i++) begin
      reset = tbl[i].rst_n; req0 = tbl[i].r0; req1 = tbl[i].r1; col0 = tbl[i].c0; col1 = tbl[i].c1;
      row0 = tbl[i].w0; row1 = tbl[i].w1; color0 = tbl[i].k0; color1 = tbl[i].k1;
      return_sig = tbl[i].ret;
      tick();
      exp_cs = (tbl[i].x_cs < 0) ? 64'd0 : (64'd1 << tbl[i].x_cs);
      n_checks++;
      if (col_select !== exp_cs || done0 !== tbl[i].x_d0 || done1 !== tbl[i].x_d1 ||
          err0 !== tbl[i].x_e0 || err1 !== tbl[i].x_e1 || busy !== tbl[i].x_busy ||
          grant_id !== tbl[i].x_gid || row_select !== tbl[i].x_row || pixel_color !== tbl[i].x_color) begin
        n_fail++;
        $display("FAIL vec%0d got cs=%h d=%b%b e=%b%b busy=%b gid=%b row=%0d col=%h exp cs=%h d=%b%b busy=%b gid=%b row=%0d col=%h",
                 i, col_select, done0, done1, err0, err1, busy, grant_id, row_select, pixel_color,
                 exp_cs, tbl[i].x_d0, tbl[i].x_d1, tbl[i].x_busy, tbl[i].x_gid, tbl[i].x_row, tbl[i].x_color);
      end
    end

    // Both requesters held: service must alternate starting with requester 0.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; col0 = 6'd2; col1 = 6'd9;
    for (int k = 0; k < 40; k++) begin
      return_sig = (m_phase == PH_WAIT) ? (64'd1 << m_col) : 64'd0;
      tick();
    end
    check("rr_count", (done_log.size() >= 4) ? 1 : 0, 1);
    for (int k = 0; k < 4 && k < done_log.size(); k++) check("rr_order", done_log[k], k % 2);

    // Timeout on column 63 with no acknowledge.
    do_reset();
    req1 = 1'b1; col1 = 6'd63; row1 = 10'd1; color1 = 8'h02; return_sig = '0;
    cnt_cs = 0; cnt_e = 0; cnt_d = 0; err_at = -1; busy_after = -1;
    for (int k = 0; k < 14; k++) begin
      tick();
      req1 = 1'b0;
      if (col_select[63]) cnt_cs++;
      if (err1) begin cnt_e++; err_at = k; end
      if (done1) cnt_d++;
      if (err_at >= 0 && k == err_at + 1) busy_after = int'(busy);
    end
    check("tmo_strobe_cycles", cnt_cs, 8);
    check("tmo_err1_pulses", cnt_e, 1);
    check("tmo_no_done1", cnt_d, 0);
    check("tmo_idle_after_flush", busy_after, 0);

    // Acknowledge on the neighbouring column must be ignored.
    do_reset();
    req0 = 1'b1; col0 = 6'd10; row0 = 10'd5; color0 = 8'h33;
    tick();
    req0 = 1'b0; return_sig = 64'd1 << 11;
    for (int k = 0; k < 5; k++) tick();
    check("wrongcol_no_done", done_log.size(), 0);
    check("wrongcol_strobe_held", int'(col_select[10]), 1);
    return_sig = 64'd1 << 10;
    tick();
    check("rightcol_done0", int'(done0), 1);
    return_sig = '0;
    tick();

    // Stuck acknowledge through RELEASE: flush without err, no grant until IDLE.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; col0 = 6'd4; col1 = 6'd7; return_sig = 64'd1 << 4;
    cnt_e = 0; busy_after = -1; gid_g = -1; cnt_cs = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      req0 = 1'b0;
      if (k <= 11 && (err0 || err1)) cnt_e++;
      if (k == 10) cnt_cs = int'(busy);
      if (k == 11) busy_after = int'(busy);
      if (k == 12) gid_g = int'(grant_id);
    end
    check("stuck_no_err", cnt_e, 0);
    check("stuck_busy_in_flush", cnt_cs, 1);
    check("stuck_idle_after_flush", busy_after, 0);
    check("stuck_next_grant_id", gid_g, 1);
    req1 = 1'b0; return_sig = '0;
    for (int k = 0; k < 10; k++) tick();

    // Reset mid-WAIT, then contention must grant requester 0.
    do_reset();
    req0 = 1'b1; col0 = 6'd3;
    tick();
    req0 = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("rstwait_cs_zero", (col_select == 64'd0) ? 1 : 0, 1);
    check("rstwait_busy", int'(busy), 0);
    check("rstwait_pulses", int'(done0 | done1 | err0 | err1), 0);
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; col0 = 6'd12; col1 = 6'd13;
    tick();
    check("rstwait_grant_id", int'(grant_id), 0);
    check("rstwait_grant_col", (col_select == (64'd1 << 12)) ? 1 : 0, 1);
    req0 = 1'b0; req1 = 1'b0;

    // Random traffic with varying acknowledge likelihood.
    plist[0] = 0; plist[1] = 25; plist[2] = 60; plist[3] = 95;
    for (int blk = 0; blk < 8; blk++) begin
      for (int k = 0; k < 250; k++) begin
        reset  = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
        req0   = 1'($urandom_range(0, 1));
        req1   = 1'($urandom_range(0, 1));
        col0   = 6'($urandom_range(0, 63));
        col1   = 6'($urandom_range(0, 63));
        row0   = 10'($urandom);
        row1   = 10'($urandom);
        color0 = 8'($urandom);
        color1 = 8'($urandom);
        r = '0;
        if ($urandom_range(0, 99) < plist[blk % 4]) r[m_col] = 1'b1;
        if ($urandom_range(0, 1) == 1) r[$urandom_range(0, 63)] = 1'b1;
        return_sig = r;
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/column_write_arbiter.md
COLUMN_WRITE_ARBITER -- requirements
Module: column_write_arbiter

Interface
REQ-001 Parameter N_COLS, default 64: number of column memories; one col_select/return_sig bit per column.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT/RELEASE cycles before a transfer is abandoned; range 2..1023.
REQ-003 Port clock, input, 1: the single clock; all state changes occur on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset.
REQ-005 Ports req0, req1, input, 1 each: pixel-write request; requester 0 is the HPS point path and requester 1 is the grid plot path.
REQ-006 Ports col0, col1, input, 6 each: target column index of each requester.
REQ-007 Ports row0, row1, input, 10 each: target row of each requester.
REQ-008 Ports color0, color1, input, 8 each: pixel value of each requester.
REQ-009 Ports done0, done1, output, 1 each: one-cycle pulse when the column acknowledged the write.
REQ-010 Ports err0, err1, output, 1 each: one-cycle pulse when the transfer timed out.
REQ-011 Port col_select, output, N_COLS: one-hot column strobe.
REQ-012 Port row_select, output, 10: row of the active transfer.
REQ-013 Port pixel_color, output, 8: pixel value of the active transfer.
REQ-014 Port return_sig, input, N_COLS: per-column acknowledge.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port grant_id, output, 1: requester owning the current or most recent transfer.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, WAIT, RELEASE and FLUSH.
REQ-018 Requests SHALL be sampled only in IDLE; req is ignored in every other state.
REQ-019 In IDLE with exactly one req high, that requester SHALL be granted.
REQ-020 In IDLE with both req high, the requester not granted last SHALL win (round-robin); after reset, requester 0 wins.
REQ-021 On grant at cycle t, the block SHALL latch col/row/color, set grant_id and move to WAIT.
REQ-022 At cycle t+1, col_select[col] SHALL be 1 and all other bits 0, with row_select and pixel_color driven from the latched values.
REQ-023 In WAIT, a cycle-counter SHALL start at 0 and increment every cycle.
REQ-024 If return_sig[latched col] is 1 at cycle u, then at u+1: col_select SHALL be all 0, done of the granted requester SHALL pulse, and the FSM SHALL enter RELEASE.
REQ-025 In WAIT, return_sig bits of any other column SHALL be ignored.
REQ-026 If the counter reaches TIMEOUT-1 with no acknowledge, then next cycle: col_select SHALL be 0, err of the granted requester SHALL pulse, and the FSM SHALL enter FLUSH.
REQ-027 On entry to RELEASE the counter SHALL restart at 0.
REQ-028 RELEASE SHALL return to IDLE once return_sig[latched col] reads 0.
REQ-029 If return_sig[latched col] stays high for TIMEOUT cycles in RELEASE, the FSM SHALL go to FLUSH without pulsing err.
REQ-030 FLUSH SHALL last exactly one cycle, then return to IDLE.
REQ-031 The minimum request-to-request spacing SHALL be 3 cycles: grant, acknowledge, release.
REQ-032 A requester still holding req in the cycle after its done/err SHALL be treated as a new request.
REQ-033 done and err SHALL never pulse in the same cycle.
REQ-034 col_select SHALL never have more than one bit set.
REQ-035 row_select and pixel_color SHALL hold their last value in IDLE.

Reset
REQ-036 While reset is 0 at a clock edge, the block SHALL enter IDLE.
REQ-037 Reset SHALL clear col_select, done0/1, err0/1, busy, grant_id and the counter, and restore round-robin priority to requester 0.
REQ-038 Reset SHALL clear row_select and pixel_color to 0.
REQ-039 Reset mid-transfer SHALL drop col_select at the same edge, with no done or err pulse.

Structure
REQ-040 Package column_arb_pkg SHALL hold N_COLS default, TIMEOUT default, the state enumeration and the col/row/color widths.
REQ-041 The round-robin pick SHALL be a sub-module rr_priority2, taking inputs req0, req1 and last and producing outputs gnt_valid and gnt_id.
REQ-042 The column-index-to-one-hot decode SHALL stay inline.

Verification
REQ-043 Single request: req0=1, col0=5, row0=17, color0=0xFF; return_sig[5] rises 3 cycles later -> col_select=1<<5 one cycle after grant; done0 pulses one cycle after return_sig[5]; busy then falls once return_sig[5]=0.
REQ-044 Simultaneous requests from reset: req0 and req1 high, col0=2, col1=9, both columns acknowledge in 1 cycle -> requester 0 served first, then requester 1; with both requests held, grants alternate 0,1,0,1.
REQ-045 Timeout: TIMEOUT=8, req1 to col 63, return_sig never asserted -> col_select[63] high for 8 cycles then 0; err1 pulses once; no done1; IDLE two cycles later.
REQ-046 Wrong-column acknowledge: transfer on col 10, return_sig[11]=1 -> ignored; completion occurs only on return_sig[10].
REQ-047 Stuck acknowledge: return_sig[4] held high through RELEASE -> FSM enters FLUSH after TIMEOUT cycles; no err; no new grant until IDLE.
REQ-048 Reset mid-WAIT: reset=0 during WAIT -> next edge col_select=0, busy=0, no pulses; the next req1 with req0=1 grants requester 0.
